// File: rtl/game_pkg.sv
// Shared button indices, arbitration order and default timing for the input path.
package game_pkg;

  localparam int NUM_BTNS = 9;
  localparam int NUM_DIR  = 4;

  typedef enum logic [3:0] {
    BTN_LEFT   = 4'd0,
    BTN_RIGHT  = 4'd1,
    BTN_UP     = 4'd2,
    BTN_DOWN   = 4'd3,
    BTN_ROTATE = 4'd4,
    BTN_PLACE  = 4'd5,
    BTN_SEL1   = 4'd6,
    BTN_SEL2   = 4'd7,
    BTN_SEL3   = 4'd8
  } btn_e;

  // Highest priority first.
  localparam btn_e PRIO_ORDER [NUM_BTNS] = '{
    BTN_SEL1, BTN_SEL2, BTN_SEL3, BTN_LEFT, BTN_RIGHT,
    BTN_UP, BTN_DOWN, BTN_ROTATE, BTN_PLACE
  };

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 15000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;
  localparam int unsigned DEF_CNT_W           = 24;

  // One-hot grant of the highest-priority requester (zero when idle).
  function automatic logic [NUM_BTNS-1:0] prio_grant(input logic [NUM_BTNS-1:0] req);
    logic [NUM_BTNS-1:0] g;
    g = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (req[PRIO_ORDER[i]]) begin
        g = '0;
        g[PRIO_ORDER[i]] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a stable-count debouncer.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic db_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, db_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      // Any agreeing cycle restarts the stability window.
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/input_controller.sv
// Turns raw push-buttons into one-at-a-time command pulses with auto-repeat
// on the direction buttons and a lock-out while the game is over.
module input_controller
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic                game_over,
  output logic                move_left,
  output logic                move_right,
  output logic                move_up,
  output logic                move_down,
  output logic                rotate_block,
  output logic                place_block,
  output logic                sel1,
  output logic                sel2,
  output logic                sel3
);

  // After a repeat fires the counter reloads so the next hit lands
  // REPEAT_PERIOD cycles later; assumes REPEAT_PERIOD <= REPEAT_DELAY.
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [NUM_BTNS-1:0]           db, db_prev_q, press, set, grant;
  logic [NUM_BTNS-1:0]           pending_q, pending_d, out_q, out_d;
  logic [NUM_DIR-1:0]            rpt_hit;
  logic [NUM_DIR-1:0][CNT_W-1:0] rpt_q, rpt_d;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_i(clk),
      .rst_i(reset),
      .btn_i(btn_raw[i]),
      .db_o (db[i])
    );
  end

  assign press = db & ~db_prev_q;

  always_comb begin
    rpt_d   = rpt_q;
    rpt_hit = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (game_over || !db[i] || press[i]) begin
        rpt_d[i] = '0;
      end else if (rpt_q[i] == RPT_LAST) begin
        rpt_d[i]   = RPT_RELOAD;
        rpt_hit[i] = 1'b1;
      end else begin
        rpt_d[i] = rpt_q[i] + 1'b1;
      end
    end
  end

  assign set   = press | {{(NUM_BTNS-NUM_DIR){1'b0}}, rpt_hit};
  assign grant = prio_grant(pending_q);

  // A set landing on the same edge as its grant keeps the bit pending.
  always_comb begin
    if (game_over) begin
      pending_d = '0;
      out_d     = '0;
    end else begin
      pending_d = (pending_q & ~grant) | set;
      out_d     = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_prev_q <= '0;
      rpt_q     <= '0;
      pending_q <= '0;
      out_q     <= '0;
    end else begin
      db_prev_q <= db;
      rpt_q     <= rpt_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  assign move_left    = out_q[BTN_LEFT];
  assign move_right   = out_q[BTN_RIGHT];
  assign move_up      = out_q[BTN_UP];
  assign move_down    = out_q[BTN_DOWN];
  assign rotate_block = out_q[BTN_ROTATE];
  assign place_block  = out_q[BTN_PLACE];
  assign sel1         = out_q[BTN_SEL1];
  assign sel2         = out_q[BTN_SEL2];
  assign sel3         = out_q[BTN_SEL3];

endmodule

// File: tb/tb_input_controller.sv
// Directed bench: expected pulses (cycle, one-hot) are queued at stimulus time
// and matched by a negedge monitor against every non-idle output cycle.
module tb_input_controller;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset, game_over;
  logic [8:0] btn_raw;
  logic       move_left, move_right, move_up, move_down;
  logic       rotate_block, place_block, sel1, sel2, sel3;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  typedef struct {
    int         cyc;
    logic [8:0] bits;
  } exp_t;
  exp_t sb[$];

  input_controller #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .CNT_W          (24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .game_over   (game_over),
    .move_left   (move_left),
    .move_right  (move_right),
    .move_up     (move_up),
    .move_down   (move_down),
    .rotate_block(rotate_block),
    .place_block (place_block),
    .sel1        (sel1),
    .sel2        (sel2),
    .sel3        (sel3)
  );

  wire [8:0] obs = {sel3, sel2, sel1, place_block, rotate_block,
                    move_down, move_up, move_right, move_left};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic expect_pulse(input int c, input logic [8:0] b);
    exp_t e;
    e.cyc  = c;
    e.bits = b;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (armed && obs != '0) begin
      check("onehot", 32'($countones(obs) <= 1), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(obs), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_bits", 32'(obs), 32'(e.bits));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; btn_raw = '0; game_over = 1'b0;
    wait_cyc(10);
    check("reset_outputs", 32'(obs), 32'd0);
    reset = 1'b0;
    armed = 1'b1;
    wait_cyc(3);

    // Clean press: pulse visible after edge 8 counting the first high sample.
    n = cyc; btn_raw[1] = 1'b1;
    expect_pulse(n + 8, 9'h002);
    wait_cyc(12); btn_raw[1] = 1'b0;
    wait_cyc(15);
    check("clean_press_done", sb.size(), 0);

    // Bounce shorter than the debounce window never qualifies.
    for (int k = 0; k < 6; k++) begin
      btn_raw[4] = ~btn_raw[4];
      wait_cyc(2);
    end
    wait_cyc(15);
    check("bounce_done", sb.size(), 0);

    // Auto-repeat on left: +0, +20, +28, +36, +44.
    n = cyc; btn_raw[0] = 1'b1;
    expect_pulse(n + 8,  9'h001);
    expect_pulse(n + 28, 9'h001);
    expect_pulse(n + 36, 9'h001);
    expect_pulse(n + 44, 9'h001);
    expect_pulse(n + 52, 9'h001);
    wait_cyc(49); btn_raw[0] = 1'b0;
    wait_cyc(20);
    check("repeat_left_done", sb.size(), 0);

    // Same hold on place: no repeat.
    n = cyc; btn_raw[5] = 1'b1;
    expect_pulse(n + 8, 9'h020);
    wait_cyc(49); btn_raw[5] = 1'b0;
    wait_cyc(20);
    check("place_no_repeat_done", sb.size(), 0);

    // sel1 and place together: sel1 first, place next cycle.
    n = cyc; btn_raw[6] = 1'b1; btn_raw[5] = 1'b1;
    expect_pulse(n + 8, 9'h040);
    expect_pulse(n + 9, 9'h020);
    wait_cyc(10); btn_raw[6] = 1'b0; btn_raw[5] = 1'b0;
    wait_cyc(15);
    check("contention2_done", sb.size(), 0);

    // sel1, right and place together: right beats place.
    n = cyc; btn_raw[6] = 1'b1; btn_raw[5] = 1'b1; btn_raw[1] = 1'b1;
    expect_pulse(n + 8,  9'h040);
    expect_pulse(n + 9,  9'h002);
    expect_pulse(n + 10, 9'h020);
    wait_cyc(10); btn_raw[6] = 1'b0; btn_raw[5] = 1'b0; btn_raw[1] = 1'b0;
    wait_cyc(15);
    check("contention3_done", sb.size(), 0);

    // Lock-out discards the press entirely.
    game_over = 1'b1;
    wait_cyc(2);
    btn_raw[5] = 1'b1; wait_cyc(10); btn_raw[5] = 1'b0;
    wait_cyc(12);
    game_over = 1'b0;
    wait_cyc(5);
    check("lockout_done", sb.size(), 0);
    n = cyc; btn_raw[5] = 1'b1;
    expect_pulse(n + 8, 9'h020);
    wait_cyc(10); btn_raw[5] = 1'b0;
    wait_cyc(15);
    check("after_lockout_done", sb.size(), 0);

    // Reset while left repeats, then release with left still held.
    n = cyc; btn_raw[0] = 1'b1;
    expect_pulse(n + 8,  9'h001);
    expect_pulse(n + 28, 9'h001);
    expect_pulse(n + 36, 9'h001);
    wait_cyc(40); reset = 1'b1;
    wait_cyc(1);
    check("reset_mid_outputs", 32'(obs), 32'd0);
    wait_cyc(4); reset = 1'b0;
    n = cyc;
    expect_pulse(n + 8,  9'h001);
    expect_pulse(n + 28, 9'h001);
    wait_cyc(27); btn_raw[0] = 1'b0;
    wait_cyc(20);
    check("reset_mid_done", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
